// File: rtl/compress_pkg.sv
// compress_pkg: shared constants, d_sel encoding and FSM states for the polynomial compress encoder
package compress_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W = 12;
  localparam int DSEL_W = 3;
  localparam int DMAX = 11;
  localparam int ACC_W = 18;
  localparam int FILL_W = 5;
  localparam int CNT_W = 9;
  typedef enum logic [DSEL_W-1:0] {DSEL_D1 = 3'd0, DSEL_D4 = 3'd1, DSEL_D5 = 3'd2, DSEL_D10 = 3'd3, DSEL_D11 = 3'd4} dsel_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  function automatic logic d_ok(logic [DSEL_W-1:0] s);
    return s <= DSEL_D11;
  endfunction
  function automatic logic [FILL_W-1:0] d_width(logic [DSEL_W-1:0] s);
    return s == DSEL_D1 ? 5'd1 : s == DSEL_D4 ? 5'd4 : s == DSEL_D5 ? 5'd5 : s == DSEL_D10 ? 5'd10 : 5'd11;
  endfunction
endpackage

// File: rtl/compress.sv
// compress: o_y = round(2^D * i_x / q) mod 2^D, purely combinational
// Ports: i_x (12-bit coefficient), o_y (D-bit compressed value)
module compress
  import compress_pkg::*;
#(
  parameter int D = 1
) (
  input  logic [COEF_W-1:0] i_x,
  output logic [D-1:0]      o_y
);
  localparam int W = COEF_W + D + 2;
  logic [W-1:0] w_num;
  // q is odd, so floor((2^(D+1)*x + q) / 2q) rounds to nearest with no ties
  assign w_num = W'({i_x, {(D + 1){1'b0}}}) + W'(KYBER_Q);
  assign o_y = D'(w_num / W'(2 * KYBER_Q));
endmodule

// File: rtl/poly_compress_encoder.sv
// poly_compress_encoder: compresses 256 coefficients at D in {1,4,5,10,11} and packs them LSB-first into bytes
// Ports: clk, rst_n (sync active-low); start/d_sel begin a polynomial; coef_valid/coef_ready/coef input stream;
//        byte_valid/byte_ready/byte_data output stream; busy, done (1-cycle pulse), range_err (sticky).
// Option: POLY_COMPRESS_RANGE_CHK_EN enables range_err for accepted coef >= q; otherwise range_err is 0.
module poly_compress_encoder
  import compress_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DSEL_W-1:0] d_sel,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic              done,
  output logic              range_err
);
  state_e r_state, w_state_nxt;
  logic [DSEL_W-1:0] r_d_sel;
  logic [FILL_W-1:0] r_d, r_fill, w_fill_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_coef_ready, r_byte_valid, r_busy, r_done;
  logic w_start, w_take, w_emit;
  logic [0:0] w_y1;
  logic [3:0] w_y4;
  logic [4:0] w_y5;
  logic [9:0] w_y10;
  logic [10:0] w_y11;
  logic [DMAX-1:0] w_res;
  compress #(.D(1)) u_c1 (.i_x(coef), .o_y(w_y1));
  compress #(.D(4)) u_c4 (.i_x(coef), .o_y(w_y4));
  compress #(.D(5)) u_c5 (.i_x(coef), .o_y(w_y5));
  compress #(.D(10)) u_c10 (.i_x(coef), .o_y(w_y10));
  compress #(.D(11)) u_c11 (.i_x(coef), .o_y(w_y11));
  always_comb begin
    w_res = r_d_sel == DSEL_D1 ? DMAX'(w_y1) : r_d_sel == DSEL_D4 ? DMAX'(w_y4) :
            r_d_sel == DSEL_D5 ? DMAX'(w_y5) : r_d_sel == DSEL_D10 ? DMAX'(w_y10) : w_y11;
    w_start = r_state == S_IDLE && start && d_ok(d_sel);
    // ready implies fill<8 and valid implies fill>=8, so take and emit never coincide
    w_take = coef_valid && r_coef_ready;
    w_emit = r_byte_valid && byte_ready;
    w_acc_nxt = w_start ? '0 : w_take ? r_acc | (ACC_W'(w_res) << r_fill) : w_emit ? r_acc >> 8 : r_acc;
    w_fill_nxt = w_start ? '0 : w_take ? r_fill + r_d : w_emit ? r_fill - 5'd8 : r_fill;
    w_cnt_nxt = w_start ? '0 : r_cnt + CNT_W'(w_take);
    w_state_nxt = r_state == S_IDLE ? (w_start ? S_RUN : S_IDLE) :
                  r_state == S_RUN ? (w_take && r_cnt == CNT_W'(KYBER_N - 1) ? S_DRAIN : S_RUN) :
                  (w_fill_nxt == '0 ? S_IDLE : S_DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_d_sel <= '0;
      r_d <= '0;
      r_fill <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_coef_ready <= 1'b0;
      r_byte_valid <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill <= w_fill_nxt;
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_coef_ready <= w_state_nxt == S_RUN && w_fill_nxt < 5'd8 && !w_cnt_nxt[CNT_W-1];
      r_byte_valid <= w_fill_nxt >= 5'd8;
      r_busy <= w_state_nxt != S_IDLE;
      r_done <= r_state == S_DRAIN && w_state_nxt == S_IDLE;
      if (w_start) begin
        r_d_sel <= d_sel;
        r_d <= d_width(d_sel);
      end
    end
  end
`ifdef POLY_COMPRESS_RANGE_CHK_EN
  logic r_range_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_range_err <= 1'b0;
    else r_range_err <= w_start ? 1'b0 : r_range_err | (w_take && coef >= COEF_W'(KYBER_Q));
  end
  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif
  assign coef_ready = r_coef_ready;
  assign byte_valid = r_byte_valid;
  assign byte_data = r_acc[7:0];
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_poly_compress_encoder.sv
// tb_poly_compress_encoder: scoreboard bench for poly_compress_encoder
module tb_poly_compress_encoder;
  logic clk = 0, rst_n = 0, start = 0, coef_valid = 0, byte_ready = 0;
  logic [2:0] d_sel = 0;
  logic [11:0] coef = 0;
  logic coef_ready, byte_valid, busy, done, range_err;
  logic [7:0] byte_data;
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  bit rnd_rdy = 0, rnd_vld = 0, held = 0;
  logic [7:0] held_d;
  int coefs[256];
  always #5 clk = ~clk;
  poly_compress_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef(coef),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .busy(busy), .done(done), .range_err(range_err)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int cmp(int d, int x);
    longint p = longint'(x) << d;
    int y = int'(p / 3329);
    if (2 * (p % 3329) >= 3329) y++;
    return y % (1 << d);
  endfunction
  task automatic push_model(int d);
    bit bits[$];
    int y;
    logic [7:0] v;
    for (int c = 0; c < 256; c++) begin
      y = cmp(d, coefs[c]);
      for (int b = 0; b < d; b++) bits.push_back(y[b]);
      while (bits.size() >= 8) begin
        for (int k = 0; k < 8; k++) v[k] = bits.pop_front();
        exp_q.push_back(v);
      end
    end
  endtask
  task automatic push_const(int n, logic [7:0] b);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask
  task automatic go(int ds);
    @(posedge clk); #1 start = 1; d_sel = 3'(ds);
    @(posedge clk); #1 start = 0;
  endtask
  task automatic feed(int n);
    int idx = 0, guard = 0;
    bit hs;
    coef_valid = 1; coef = 12'(coefs[0]);
    while (idx < n && guard < 20000) begin
      @(negedge clk); hs = coef_valid && coef_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
      coef_valid = idx < n && (!rnd_vld || $urandom_range(0, 1) == 1);
      coef = 12'(coefs[idx & 255]);
    end
    coef_valid = 0;
    chk("coefs_fed", idx, n);
  endtask
  task automatic wait_done(string nm);
    int d0 = done_cnt;
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clk);
    @(negedge clk);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_left"}, exp_q.size(), 0);
  endtask
  task automatic run(int ds, string nm);
    go(ds);
    feed(256);
    wait_done(nm);
  endtask
  initial forever begin
    @(posedge clk); #1 byte_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      held = 0;
      continue;
    end
    if (byte_valid && held) chk("stall_hold", byte_data, held_d);
    if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra_byte: got %0h expected none", byte_data);
      end else chk("byte", byte_data, exp_q.pop_front());
    end
    held = byte_valid && !byte_ready;
    held_d = byte_data;
    if (done) done_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_range_err", range_err, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", coef_ready, 0);
    chk("post_rst_busy", busy, 0);
    foreach (coefs[i]) coefs[i] = 1665;
    push_const(32, 8'hFF);
    run(0, "d1");
    foreach (coefs[i]) coefs[i] = (i % 2) ? 1665 : 0;
    push_const(128, 8'h80);
    run(1, "d4");
    foreach (coefs[i]) coefs[i] = 3328;
    push_const(320, 8'h00);
    run(3, "d10");
    foreach (coefs[i]) coefs[i] = int'($urandom_range(0, 3328));
    push_model(11);
    rnd_vld = 1; rnd_rdy = 1;
    run(4, "d11");
    rnd_vld = 0; rnd_rdy = 0;
    foreach (coefs[i]) coefs[i] = (i * 13) % 3329;
    push_model(5);
    go(2);
    feed(100);
    d0 = done_cnt;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_byte_valid", byte_valid, 0);
    chk("abort_ready", coef_ready, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    foreach (coefs[i]) coefs[i] = (i * 977 + 5) % 3329;
    push_model(5);
    run(2, "d5");
    go(6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bad_dsel_busy", busy, 0);
    end
    chk("bad_dsel_ready", coef_ready, 0);
`ifdef POLY_COMPRESS_RANGE_CHK_EN
    foreach (coefs[i]) coefs[i] = 0;
    coefs[3] = 3329;
    coefs[9] = 1665;
    push_model(4);
    run(1, "range");
    chk("range_err_set", range_err, 1);
    foreach (coefs[i]) coefs[i] = 0;
    push_const(32, 8'h00);
    go(0);
    @(negedge clk);
    chk("range_err_clr", range_err, 0);
    feed(256);
    wait_done("range_clr");
`else
    chk("range_err_off", range_err, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/poly_compress_encoder.md
POLY_COMPRESS_ENCODER -- requirements
Module: poly_compress_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: start  in  1  begin one 256-coefficient polynomial; d_sel  in  3  compression select.
REQ-004 SHALL have ports: coef_valid  in  1; coef_ready  out  1; coef  in  12  coefficient in [0,3328].
REQ-005 SHALL have ports: byte_valid  out  1; byte_ready  in  1; byte_data  out  8.
REQ-006 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; range_err  out  1  sticky.

Function
REQ-007 SHALL encode d_sel as 0=D1, 1=D4, 2=D5, 3=D10, 4=D11; the codes 5..7 are invalid.
REQ-008 SHALL compute each coefficient as round(2^D*x/3329) mod 2^D, bit-exact with the compress datapath.
REQ-009 SHALL run an FSM with states IDLE, RUN and DRAIN.
REQ-010 SHALL move IDLE->RUN on start with a valid d_sel, latching D for the whole polynomial.
REQ-011 SHALL ignore start when d_sel is invalid or the FSM is not in IDLE.
REQ-012 SHALL assert coef_ready only in RUN with accumulator fill < 8 and fewer than 256 coefficients accepted.
REQ-013 SHALL accept a coefficient on coef_valid&coef_ready, appending its D result bits LSB-first at bit position fill of an 18-bit accumulator.
REQ-014 SHALL register byte_valid and assert it whenever fill >= 8, with byte_data = acc[7:0].
REQ-015 SHALL, on byte_valid&byte_ready, shift the accumulator right by 8 and reduce fill by 8.
REQ-016 SHALL hold byte_data stable while byte_valid=1 and byte_ready=0.
REQ-017 SHALL never accept a coefficient and emit a byte in the same cycle, because the fill<8 and fill>=8 conditions are exclusive.
REQ-018 SHALL make bits of a coefficient accepted in cycle N visible on byte_data no earlier than cycle N+1.
REQ-019 SHALL move RUN->DRAIN after the 256th coefficient is accepted.
REQ-020 SHALL move DRAIN->IDLE when fill reaches 0, pulsing done for exactly one cycle; fill is exact because 256*D is divisible by 8.
REQ-021 SHALL emit exactly 32*D bytes per polynomial: 32, 128, 160, 320 or 352.
REQ-022 SHALL assert busy in RUN and DRAIN, and deassert it in IDLE.
REQ-023 SHALL use a 9-bit coefficient counter that is cleared on each start and does not wrap.

Reset
REQ-024 SHALL, on a cycle with rst_n=0, place the FSM in IDLE and clear acc, fill, the counter and range_err.
REQ-025 SHALL drive coef_ready=0, byte_valid=0, busy=0 and done=0 during and immediately after reset.
REQ-026 SHALL, on reset mid-polynomial, discard all partial output with no done pulse.
REQ-027 SHALL clear range_err on reset and on each accepted start.

Configuration
REQ-028 SHALL, with POLY_COMPRESS_RANGE_CHK_EN defined, set range_err when an accepted coef >= 3329, while still compressing that value as given.
REQ-029 SHALL, without POLY_COMPRESS_RANGE_CHK_EN, tie range_err to 0 and remove the comparator logic.

Structure
REQ-030 SHALL take KYBER_Q=3329, KYBER_N=256 and the d_sel encoding and width constants from shared package compress_pkg.
REQ-031 SHALL instantiate the existing compress sub-module once per D value (1,4,5,10,11), with a latched-D mux selecting the result.
REQ-032 SHALL keep all other logic (FSM, accumulator, counter) in a single module with no further sub-modules.

Verification
REQ-033 SHALL cover: D1, 256 coefs of 1665, byte_ready=1 -> 32 bytes 0xFF, then a done pulse, then busy=0.
REQ-034 SHALL cover: D4, coefs alternating 0 and 1665 (results 0 and 8) -> 128 bytes 0x80.
REQ-035 SHALL cover: D10, all coefs 3328 -> 320 bytes 0x00, exercising the mod-1024 wrap.
REQ-036 SHALL cover: D11 with random coefs, random coef_valid and random byte_ready -> 352 bytes matching the model, with byte_data stable under stall.
REQ-037 SHALL cover: rst_n=0 asserted after 100 coefs at D5, followed by a new start at D5 -> a clean 160-byte output, with no done pulse from the aborted run.
REQ-038 SHALL cover: start with d_sel=6 -> start ignored and busy stays 0; with POLY_COMPRESS_RANGE_CHK_EN, coef 3329 at D4 -> range_err=1 until the next start.
